// File: rtl/dvp_tx_frame_gen_if.sv
// -----------------------------------------------------------------------------
// dvp_tx_frame_gen_if
//   Pixel-stream handshake feeding the DVP transmitter.
//
//   s_data  : 16-bit RGB565 pixel, [15:8] leaves the transmitter first
//   s_valid : source has a pixel on s_data
//   s_ready : transmitter takes the pixel in this clk when s_valid=1
//
//   master : pixel source (drives s_data/s_valid, observes s_ready)
//   slave  : dvp_tx_frame_gen (observes s_data/s_valid, drives s_ready)
// -----------------------------------------------------------------------------
interface dvp_tx_frame_gen_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/dvp_tx_frame_gen.sv
// -----------------------------------------------------------------------------
// dvp_tx_frame_gen
//   Camera-side DVP transmitter. Turns a 16-bit RGB565 valid/ready pixel
//   stream into DVP signalling (pclk, vsync, href, 8-bit data). Used as an
//   on-chip camera emulator and as a loopback source for the DVP receiver.
//
//   pclk is clk divided by PCLK_DIV (even, >= 2). Every DVP output changes
//   on the pclk falling event ("tick"), so a receiver sampling on the pclk
//   rising edge always sees settled data.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   tx_en        in   transmit enable; sampled only in IDLE and at frame end
//   pix          slave pixel stream (s_data / s_valid / s_ready)
//   dvp_pclk_o   out  pixel clock
//   dvp_vsync_o  out  frame sync, active-high
//   dvp_href_o   out  line valid, active-high
//   dvp_data_o   out  pixel byte, 0 whenever href is low
//   busy_o       out  frame generator not idle
//   frame_done_o out  one-clk pulse as each frame ends
//   underflow_o  out  sticky: a pixel slot found no valid pixel
// -----------------------------------------------------------------------------
module dvp_tx_frame_gen #(
  parameter int PCLK_DIV  = 6,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 1568,
  parameter int VBP_CYC   = 12544,
  parameter int VFP_CYC   = 1568
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  dvp_tx_frame_gen_if.slave    pix,
  output logic                 dvp_pclk_o,
  output logic                 dvp_vsync_o,
  output logic                 dvp_href_o,
  output logic [7:0]           dvp_data_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 underflow_o
);

  // Larger of two integers, used to size the shared state-length counter.
  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  localparam int ACT_CYC = 2 * H_ACTIVE;
  localparam int MAX_CYC = max2(max2(max2(VSYNC_CYC, VBP_CYC), max2(ACT_CYC, H_BLANK)), VFP_CYC);
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam int DIV_W   = $clog2(PCLK_DIV);
  localparam int LINE_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              phase_q, phase_d;   // 0: next ACTIVE tick sends a high byte
  logic [7:0]        lo_q, lo_d;         // low byte of the pixel in flight
  logic              pclk_q, pclk_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              uflow_q, uflow_d;

  logic              tick_s;
  logic              last_s;
  logic              more_lines_s;
  logic              go_active_s;
  logic              fetch_s;
  logic [CYC_W-1:0]  len_m1_s;

  // The divider sits at 0 in IDLE, so every idle clk is a tick and a
  // frame can start on the clk right after tx_en is seen.
  assign tick_s       = (div_q == {DIV_W{1'b0}});
  assign last_s       = (cyc_q == len_m1_s);
  assign more_lines_s = (line_q != LINE_W'(V_ACTIVE - 1));

  // The next pclk period is an ACTIVE one. Built only from registers so
  // s_ready never has a path from s_valid or tx_en.
  assign go_active_s  = tick_s &
                        (((state_q == ST_VBP)    &  last_s) |
                         ((state_q == ST_ACTIVE) & ~last_s) |
                         ((state_q == ST_HBLANK) &  last_s & more_lines_s));
  assign fetch_s      = go_active_s & ~phase_q;
  assign pix.s_ready  = fetch_s;

  // Final tick count of the state currently being held.
  always_comb begin
    len_m1_s = {CYC_W{1'b0}};
    case (state_q)
      ST_VSYNC:  len_m1_s = CYC_W'(VSYNC_CYC - 1);
      ST_VBP:    len_m1_s = CYC_W'(VBP_CYC - 1);
      ST_ACTIVE: len_m1_s = CYC_W'(ACT_CYC - 1);
      ST_HBLANK: len_m1_s = CYC_W'(H_BLANK - 1);
      ST_VFP:    len_m1_s = CYC_W'(VFP_CYC - 1);
      default:   len_m1_s = {CYC_W{1'b0}};
    endcase
  end

  // Frame FSM next state, counters and the registered DVP output values.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    line_d  = line_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    done_d  = 1'b0;
    uflow_d = uflow_q;

    if (tick_s) begin
      // The entry tick of a state is tick 0 of that state.
      if (last_s) begin
        cyc_d = {CYC_W{1'b0}};
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (tx_en) begin
            state_d = ST_VSYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_VSYNC: begin
          if (last_s) begin
            state_d = ST_VBP;
          end else begin
            state_d = ST_VSYNC;
          end
        end
        ST_VBP: begin
          if (last_s) begin
            state_d = ST_ACTIVE;
            line_d  = {LINE_W{1'b0}};
          end else begin
            state_d = ST_VBP;
          end
        end
        ST_ACTIVE: begin
          if (last_s) begin
            state_d = ST_HBLANK;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_HBLANK: begin
          if (last_s && more_lines_s) begin
            state_d = ST_ACTIVE;
            line_d  = line_q + LINE_W'(1);
          end else if (last_s) begin
            state_d = ST_VFP;
          end else begin
            state_d = ST_HBLANK;
          end
        end
        ST_VFP: begin
          if (last_s) begin
            done_d = 1'b1;
            if (tx_en) begin
              state_d = ST_VSYNC;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_VFP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE);

      // Pixel slots are fixed: a starved slot still sends two zero bytes.
      if (fetch_s) begin
        phase_d = 1'b1;
        if (pix.s_valid) begin
          data_d = pix.s_data[15:8];
          lo_d   = pix.s_data[7:0];
        end else begin
          data_d = 8'h00;
          lo_d   = 8'h00;
        end
      end else if (go_active_s) begin
        phase_d = 1'b0;
        data_d  = lo_q;
      end else begin
        phase_d = 1'b0;
        data_d  = 8'h00;
      end
    end else begin
      state_d = state_q;
    end

    // Underflow clears only while parked in IDLE with transmit disabled.
    if ((state_q == ST_IDLE) && !tx_en) begin
      uflow_d = 1'b0;
    end else if (fetch_s && !pix.s_valid) begin
      uflow_d = 1'b1;
    end else begin
      uflow_d = uflow_q;
    end
  end

  // Pixel-clock divider and pclk waveform: low from the tick, high from
  // mid-period, parked low in IDLE.
  always_comb begin
    div_d  = div_q;
    pclk_d = pclk_q;
    busy_d = (state_d != ST_IDLE);

    if (state_d == ST_IDLE) begin
      div_d = {DIV_W{1'b0}};
    end else if (div_q == DIV_W'(PCLK_DIV - 1)) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (state_d == ST_IDLE) begin
      pclk_d = 1'b0;
    end else if (tick_s) begin
      pclk_d = 1'b0;
    end else if (div_q == DIV_W'(PCLK_DIV / 2)) begin
      pclk_d = 1'b1;
    end else begin
      pclk_d = pclk_q;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= {DIV_W{1'b0}};
      cyc_q   <= {CYC_W{1'b0}};
      line_q  <= {LINE_W{1'b0}};
      phase_q <= 1'b0;
      lo_q    <= 8'h00;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      line_q  <= line_d;
      phase_q <= phase_d;
      lo_q    <= lo_d;
      pclk_q  <= pclk_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      uflow_q <= uflow_d;
    end
  end

  assign dvp_pclk_o   = pclk_q;
  assign dvp_vsync_o  = vsync_q;
  assign dvp_href_o   = href_q;
  assign dvp_data_o   = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign underflow_o  = uflow_q;

endmodule

// File: tb/tb_dvp_tx_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_dvp_tx_frame_gen
//   Self-checking bench for dvp_tx_frame_gen. Expected DVP waveforms come
//   from a frame-timing model that maps clk offset -> pclk period -> region
//   (vsync / back porch / line / blank / front porch) with plain arithmetic.
//   The pixel source offers one pre-chosen word per pixel slot; a slot may
//   be marked as starved (s_valid low).
// -----------------------------------------------------------------------------
module tb_dvp_tx_frame_gen;
  localparam int PCLK_DIV  = 4;
  localparam int H_ACTIVE  = 4;
  localparam int V_ACTIVE  = 2;
  localparam int H_BLANK   = 3;
  localparam int VSYNC_CYC = 2;
  localparam int VBP_CYC   = 2;
  localparam int VFP_CYC   = 2;

  localparam int LINE_P        = 2 * H_ACTIVE + H_BLANK;
  localparam int FIRST_LINE_P  = VSYNC_CYC + VBP_CYC;
  localparam int ACTIVE_END_P  = FIRST_LINE_P + V_ACTIVE * LINE_P;
  localparam int FRAME_P       = ACTIVE_END_P + VFP_CYC;
  localparam int FRAME_CLK     = FRAME_P * PCLK_DIV;
  localparam int PIX_PER_FRAME = H_ACTIVE * V_ACTIVE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       pclk, vsync, href, busy, fdone, uflow;
  logic [7:0] data;

  dvp_tx_frame_gen_if pix();

  dvp_tx_frame_gen #(
    .PCLK_DIV (PCLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VSYNC_CYC(VSYNC_CYC),
    .VBP_CYC  (VBP_CYC),
    .VFP_CYC  (VFP_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .pix         (pix),
    .dvp_pclk_o  (pclk),
    .dvp_vsync_o (vsync),
    .dvp_href_o  (href),
    .dvp_data_o  (data),
    .busy_o      (busy),
    .frame_done_o(fdone),
    .underflow_o (uflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] slot_val  [0:63];
  bit          slot_drop [0:63];
  int          slot      = 0;
  int          hs_count  = 0;

  // Pixel source: offers slot[slot] and moves on after each s_ready clk.
  initial begin
    bit taken;
    pix.s_valid = 1'b0;
    pix.s_data  = 16'h0000;
    forever begin
      pix.s_valid = !slot_drop[slot & 63];
      pix.s_data  = slot_val[slot & 63];
      @(negedge clk);
      taken = pix.s_ready;
      if (taken && pix.s_valid) hs_count++;
      @(posedge clk);
      #1;
      if (taken) slot++;
    end
  end

  // Expected DVP outputs t clks after the tick that started frame f.
  function automatic void model(input int t, input int f,
                                output logic e_pclk, output logic e_vsync,
                                output logic e_href, output logic e_rdy,
                                output logic [7:0] e_data);
    int p, q, g, p1, q1;
    logic [15:0] w;
    p       = t / PCLK_DIV;
    e_pclk  = ((t % PCLK_DIV) >= (PCLK_DIV / 2));
    e_vsync = (p < VSYNC_CYC);
    e_href  = 1'b0;
    e_rdy   = 1'b0;
    e_data  = 8'h00;
    if (p >= FIRST_LINE_P && p < ACTIVE_END_P) begin
      q = (p - FIRST_LINE_P) % LINE_P;
      if (q < 2 * H_ACTIVE) begin
        e_href = 1'b1;
        g      = (f * PIX_PER_FRAME + ((p - FIRST_LINE_P) / LINE_P) * H_ACTIVE + q / 2) & 63;
        w      = slot_drop[g] ? 16'h0000 : slot_val[g];
        e_data = (q % 2 == 0) ? w[15:8] : w[7:0];
      end
    end
    // A pixel is requested in the last clk before its high byte goes out.
    if ((t % PCLK_DIV) == PCLK_DIV - 1) begin
      p1 = p + 1;
      if (p1 >= FIRST_LINE_P && p1 < ACTIVE_END_P) begin
        q1    = (p1 - FIRST_LINE_P) % LINE_P;
        e_rdy = (q1 < 2 * H_ACTIVE) && (q1 % 2 == 0);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pclk, vsync, href, data, busy, fdone, uflow, pix.s_ready} !== 15'd0) begin
      fails++;
      $display("FAIL reset_hold got %b want 0", {pclk, vsync, href, data, busy, fdone, uflow, pix.s_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({pclk, vsync, href, data, busy, fdone, uflow, pix.s_ready} !== 15'd0) begin
        fails++;
        $display("FAIL idle clk=%0d got %b want 0", i, {pclk, vsync, href, data, busy, fdone, uflow, pix.s_ready});
      end
    end
  endtask

  task automatic test_single_frame();
    logic ep, ev, eh, er, eb, efd;
    logic [7:0] ed;
    for (int j = 0; j < 64; j++) begin
      slot_val[j]  = 16'h1234 + 16'(j) * 16'h4444;
      slot_drop[j] = 1'b0;
    end
    slot = 0;
    hs_count = 0;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    for (int t = 0; t <= FRAME_CLK + 2; t++) begin
      if (t < FRAME_CLK) model(t, 0, ep, ev, eh, er, ed);
      else begin ep = 0; ev = 0; eh = 0; er = 0; ed = 8'h00; end
      eb  = (t < FRAME_CLK);
      efd = (t == FRAME_CLK);
      checks++;
      if ({pclk, vsync, href, data, pix.s_ready} !== {ep, ev, eh, ed, er}) begin
        fails++;
        $display("FAIL single_dvp t=%0d got p%b v%b h%b d%h r%b want p%b v%b h%b d%h r%b",
                 t, pclk, vsync, href, data, pix.s_ready, ep, ev, eh, ed, er);
      end
      checks++;
      if ({busy, fdone, uflow} !== {eb, efd, 1'b0}) begin
        fails++;
        $display("FAIL single_status t=%0d got busy%b done%b uf%b want busy%b done%b uf0",
                 t, busy, fdone, uflow, eb, efd);
      end
      @(negedge clk);
    end
    checks++;
    if (hs_count !== PIX_PER_FRAME) begin
      fails++;
      $display("FAIL single_handshakes got %0d want %0d", hs_count, PIX_PER_FRAME);
    end
  endtask

  task automatic test_continuous();
    logic ep, ev, eh, er, eb, efd;
    logic [7:0] ed;
    int fd_seen, rises;
    logic prev_v;
    for (int j = 0; j < 64; j++) begin
      slot_val[j]  = 16'($urandom);
      slot_drop[j] = 1'b0;
    end
    slot = 0;
    hs_count = 0;
    fd_seen = 0;
    rises = 0;
    prev_v = 1'b0;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 3 * FRAME_CLK + 2; t++) begin
      if (t == 2 * FRAME_CLK + 40) tx_en = 1'b0;
      if (t < 3 * FRAME_CLK) model(t % FRAME_CLK, t / FRAME_CLK, ep, ev, eh, er, ed);
      else begin ep = 0; ev = 0; eh = 0; er = 0; ed = 8'h00; end
      eb  = (t < 3 * FRAME_CLK);
      efd = (t > 0) && (t % FRAME_CLK == 0) && (t <= 3 * FRAME_CLK);
      checks++;
      if ({pclk, vsync, href, data, pix.s_ready} !== {ep, ev, eh, ed, er}) begin
        fails++;
        $display("FAIL cont_dvp t=%0d got p%b v%b h%b d%h r%b want p%b v%b h%b d%h r%b",
                 t, pclk, vsync, href, data, pix.s_ready, ep, ev, eh, ed, er);
      end
      checks++;
      if ({busy, fdone, uflow} !== {eb, efd, 1'b0}) begin
        fails++;
        $display("FAIL cont_status t=%0d got busy%b done%b uf%b want busy%b done%b uf0",
                 t, busy, fdone, uflow, eb, efd);
      end
      if (fdone === 1'b1) fd_seen++;
      if (vsync === 1'b1 && prev_v === 1'b0) rises++;
      prev_v = vsync;
      @(negedge clk);
    end
    checks++;
    if (hs_count !== 3 * PIX_PER_FRAME) begin
      fails++;
      $display("FAIL cont_handshakes got %0d want %0d", hs_count, 3 * PIX_PER_FRAME);
    end
    checks++;
    if (fd_seen !== 3 || rises !== 3) begin
      fails++;
      $display("FAIL cont_counts got done=%0d vsync_rises=%0d want 3 and 3", fd_seen, rises);
    end
  endtask

  task automatic test_underflow();
    logic ep, ev, eh, er, eb, efd, euf;
    logic [7:0] ed;
    int uf_t;
    uf_t = (FIRST_LINE_P + 2 * 2) * PCLK_DIV;   // high byte of pixel 2, line 0
    for (int j = 0; j < 64; j++) begin
      slot_val[j]  = 16'($urandom) | 16'h0101;
      slot_drop[j] = 1'b0;
    end
    slot_drop[2] = 1'b1;
    slot = 0;
    hs_count = 0;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 2 * FRAME_CLK + 3; t++) begin
      if (t == FRAME_CLK + 30) tx_en = 1'b0;
      if (t < 2 * FRAME_CLK) model(t % FRAME_CLK, t / FRAME_CLK, ep, ev, eh, er, ed);
      else begin ep = 0; ev = 0; eh = 0; er = 0; ed = 8'h00; end
      eb  = (t < 2 * FRAME_CLK);
      efd = (t == FRAME_CLK) || (t == 2 * FRAME_CLK);
      euf = (t >= uf_t) && (t <= 2 * FRAME_CLK);
      checks++;
      if ({pclk, vsync, href, data, pix.s_ready} !== {ep, ev, eh, ed, er}) begin
        fails++;
        $display("FAIL uflow_dvp t=%0d got p%b v%b h%b d%h r%b want p%b v%b h%b d%h r%b",
                 t, pclk, vsync, href, data, pix.s_ready, ep, ev, eh, ed, er);
      end
      checks++;
      if ({busy, fdone, uflow} !== {eb, efd, euf}) begin
        fails++;
        $display("FAIL uflow_status t=%0d got busy%b done%b uf%b want busy%b done%b uf%b",
                 t, busy, fdone, uflow, eb, efd, euf);
      end
      @(negedge clk);
    end
    checks++;
    if (hs_count !== 2 * PIX_PER_FRAME - 1) begin
      fails++;
      $display("FAIL uflow_handshakes got %0d want %0d", hs_count, 2 * PIX_PER_FRAME - 1);
    end
    slot_drop[2] = 1'b0;
  endtask

  task automatic test_mid_disable();
    logic ep, ev, eh, er, eb, efd;
    logic [7:0] ed;
    for (int j = 0; j < 64; j++) slot_val[j] = 16'($urandom);
    slot = 0;
    hs_count = 0;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= FRAME_CLK + 8; t++) begin
      if (t == 20) tx_en = 1'b0;   // inside line 0
      if (t < FRAME_CLK) model(t, 0, ep, ev, eh, er, ed);
      else begin ep = 0; ev = 0; eh = 0; er = 0; ed = 8'h00; end
      eb  = (t < FRAME_CLK);
      efd = (t == FRAME_CLK);
      checks++;
      if ({pclk, vsync, href, data, pix.s_ready} !== {ep, ev, eh, ed, er}) begin
        fails++;
        $display("FAIL dis_dvp t=%0d got p%b v%b h%b d%h r%b want p%b v%b h%b d%h r%b",
                 t, pclk, vsync, href, data, pix.s_ready, ep, ev, eh, ed, er);
      end
      checks++;
      if ({busy, fdone} !== {eb, efd}) begin
        fails++;
        $display("FAIL dis_status t=%0d got busy%b done%b want busy%b done%b", t, busy, fdone, eb, efd);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic ep, ev, eh, er, eb, efd;
    logic [7:0] ed;
    for (int j = 0; j < 64; j++) slot_val[j] = 16'($urandom);
    slot = 0;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    repeat (42) @(negedge clk);   // mid pixel in line 0, pclk high
    checks++;
    if ({pclk, href, busy} !== 3'b111) begin
      fails++;
      $display("FAIL rst_precheck got p%b h%b busy%b want 111", pclk, href, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pclk, vsync, href, data, busy, pix.s_ready} !== 13'd0) begin
      fails++;
      $display("FAIL rst_async got %b want 0", {pclk, vsync, href, data, busy, pix.s_ready});
    end
    repeat (2) @(negedge clk);
    slot = 0;
    hs_count = 0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= FRAME_CLK + 2; t++) begin
      if (t == 10) tx_en = 1'b0;
      if (t < FRAME_CLK) model(t, 0, ep, ev, eh, er, ed);
      else begin ep = 0; ev = 0; eh = 0; er = 0; ed = 8'h00; end
      eb  = (t < FRAME_CLK);
      efd = (t == FRAME_CLK);
      checks++;
      if ({pclk, vsync, href, data, pix.s_ready} !== {ep, ev, eh, ed, er}) begin
        fails++;
        $display("FAIL rst_dvp t=%0d got p%b v%b h%b d%h r%b want p%b v%b h%b d%h r%b",
                 t, pclk, vsync, href, data, pix.s_ready, ep, ev, eh, ed, er);
      end
      checks++;
      if ({busy, fdone, uflow} !== {eb, efd, 1'b0}) begin
        fails++;
        $display("FAIL rst_status t=%0d got busy%b done%b uf%b want busy%b done%b uf0",
                 t, busy, fdone, uflow, eb, efd);
      end
      @(negedge clk);
    end
    checks++;
    if (hs_count !== PIX_PER_FRAME) begin
      fails++;
      $display("FAIL rst_handshakes got %0d want %0d", hs_count, PIX_PER_FRAME);
    end
  endtask

  initial begin
    for (int j = 0; j < 64; j++) begin
      slot_val[j]  = 16'h0000;
      slot_drop[j] = 1'b0;
    end
    test_reset();
    test_single_frame();
    test_continuous();
    test_underflow();
    test_mid_disable();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule

// File: doc/dvp_tx_frame_gen.md
Name: dvp_tx_frame_gen

Overview:
- DVP transmitter: the camera-side end of the DVP interface.
- Converts an internal 16-bit pixel stream (RGB565, valid/ready) into DVP signalling: pclk, vsync, href and 8-bit data.
- Used as an on-chip camera emulator and loopback source for the DVP RX controller.
- pclk is derived from clk by an integer divider. All DVP outputs change on the pclk falling event, so a receiver sampling on the pclk rising edge sees stable data.

Parameters:
- PCLK_DIV, 6, clk cycles per pclk period; even, >=2 (125 MHz/6 = 20.8 MHz, below the 24 MHz camera max).
- H_ACTIVE, 640, pixels per line; each pixel is 2 bytes, so 2*H_ACTIVE pclk of href high.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, pclk periods of href low after each active line.
- VSYNC_CYC, 1568, pclk periods of vsync high at frame start.
- VBP_CYC, 12544, pclk periods between vsync fall and the first line.
- VFP_CYC, 1568, pclk periods after the last line's blank.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- tx_en  in  1  transmit enable (CSR)
- s_data  in  16  pixel; [15:8] is sent first
- s_valid  in  1  pixel available
- s_ready  out  1  pixel accepted this clk when s_valid=1
- dvp_pclk_o  out  1  pixel clock
- dvp_vsync_o  out  1  frame sync, active-high
- dvp_href_o  out  1  line valid, active-high
- dvp_data_o  out  8  pixel byte
- busy_o  out  1  FSM not in IDLE
- frame_done_o  out  1  1-clk pulse at end of each frame
- underflow_o  out  1  sticky pixel-starvation flag

Behaviour:
- Reset: all outputs 0; FSM in IDLE; divider, cycle, line and byte counters 0; underflow cleared. Reset mid-frame aborts immediately, with no partial-line completion.
- Divider: counts 0..PCLK_DIV-1 while busy, then wraps.
  - tick = (div_cnt==0): the pclk falling event. pclk_o goes 0 on tick.
  - pclk_o goes 1 at div_cnt==PCLK_DIV/2.
  - In IDLE the divider is held at 0 and pclk_o at 0.
- All of vsync/href/data are registered and update only in tick cycles.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP. A state lasting N pclk periods spans exactly N ticks.
  - IDLE: on tx_en=1, the next clk is the first tick and enters VSYNC (vsync_o=1). vsync rises 1 clk after tx_en is sampled high.
  - VSYNC: lasts VSYNC_CYC ticks, then VBP (vsync_o=0).
  - VBP: lasts VBP_CYC ticks, then ACTIVE (href_o=1).
  - ACTIVE: lasts 2*H_ACTIVE ticks, then HBLANK (href_o=0, data_o=0).
  - HBLANK: lasts H_BLANK ticks. If line_cnt < V_ACTIVE-1, increment line_cnt and go to ACTIVE; else go to VFP.
  - VFP: lasts VFP_CYC ticks. At its final tick, frame_done_o pulses for that clk. Next state is VSYNC if tx_en=1, else IDLE.
- tx_en deassertion mid-frame: the current frame always completes. tx_en is only sampled in IDLE and at the end of VFP.
- Pixel fetch:
  - s_ready = tick & (next state is ACTIVE) & (byte_phase==0). It is combinational from internal registers only and never depends on s_valid.
  - If s_valid=1 on that cycle: data_o <= s_data[15:8] and the low byte is held.
  - On the following tick: data_o <= the held low byte; byte_phase toggles.
  - If s_valid=0: both bytes of that pixel are sent as 0x00 and underflow_o is set. Pixel slot timing is never stretched.
- underflow_o clears only on reset or in IDLE with tx_en=0.
- data_o = 0 whenever href_o = 0.
- Counter widths use $clog2 of each parameter (+1 as needed). No counter wraps except the divider.
- Frame length: VSYNC_CYC + VBP_CYC + V_ACTIVE*(2*H_ACTIVE+H_BLANK) + VFP_CYC pclk periods.

Test Plan:
- Bench parameters for all cases: PCLK_DIV=4, H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_CYC=2, VBP_CYC=2, VFP_CYC=2 (frame = 28 pclk = 112 clk).
- Reset and idle: assert rst_n=0, then release with tx_en=0 -> all outputs 0, pclk stays 0 for 100 clk, busy_o=0.
- Single frame, always-valid source: feed pixels 0x1234, 0x5678, ... and pulse tx_en for one frame.
  - vsync high 8 clk, rising 1 clk after tx_en.
  - href high 2 lines x 8 pclk, data sequence 12,34,56,78,...
  - frame_done_o pulses once at clk 112; then IDLE.
- Continuous mode: hold tx_en=1 for 3 frames -> vsync rises every 112 clk with no gap, 3 frame_done pulses, exactly 24 s_ready handshakes.
- Underflow: drop s_valid for the 3rd pixel of line 0 -> that pixel is sent as 00,00; href timing unchanged; underflow_o=1 stays set until tx_en=0 in IDLE.
- Mid-frame disable: deassert tx_en during line 0 -> frame completes (28 pclk) and busy_o drops after frame_done.
- Mid-frame reset: assert rst_n=0 during ACTIVE -> pclk, href and data go 0 asynchronously; after release a fresh frame starts with vsync.
